// File: rtl/conv_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_packer
// Purpose  : Packs a raster-order 4-bit pixel stream into the 5x5 frame word
//            used by the 3x3 convolution core. Pixel k = row*COLS+col goes to
//            frame bits [PIX_W*k +: PIX_W]. An assembly buffer and an output
//            holding register let one frame fill while the previous one waits.
// Revision : 1.0 - initial release
// ============================================================================
module conv_frame_packer #(
  parameter int PIX_W = 4,
  parameter int ROWS  = 5,
  parameter int COLS  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PIX_W-1:0]            pix_in,
  input  logic                        pix_valid,
  input  logic                        pix_sof,
  output logic                        pix_ready,
  output logic [ROWS*COLS*PIX_W-1:0]  frame_out,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [4:0]                  pix_cnt,
  output logic                        err_sof
);

  localparam int                NPIX     = ROWS * COLS;
  localparam int                FW       = NPIX * PIX_W;
  localparam int                CNT_W    = 5;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

  // FILL: accepting pixels. FULL: a complete frame sits in the assembly
  // buffer because the output register is still occupied.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t                         state_q;
  state_t                         state_d;

  logic [NPIX-1:0][PIX_W-1:0]     asm_q;
  logic [FW-1:0]                  asm_flat;

  logic                           accept;
  logic                           consume;
  logic                           slot_free;

  logic                           wr_en;
  logic [CNT_W-1:0]               wr_idx;
  logic [CNT_W-1:0]               cnt_d;
  logic                           load_direct;
  logic                           load_asm;
  logic                           sof_abort;

  assign asm_flat  = asm_q;
  assign pix_ready = (state_q == ST_FILL);
  assign accept    = pix_valid & pix_ready;
  assign consume   = frame_valid & frame_ready;
  // The output register can take a new frame if empty or emptying now.
  assign slot_free = ~frame_valid | frame_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    wr_idx      = pix_cnt;
    cnt_d       = pix_cnt;
    load_direct = 1'b0;
    load_asm    = 1'b0;
    sof_abort   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (pix_sof) begin
            // An sof pixel always restarts at slot 0, even at the last index.
            wr_en     = 1'b1;
            wr_idx    = '0;
            cnt_d     = ONE;
            sof_abort = (pix_cnt != '0);
          end else if (pix_cnt == LAST_IDX) begin
            if (slot_free) begin
              // Bypass the last slot straight into the output register.
              load_direct = 1'b1;
              cnt_d       = '0;
            end else begin
              wr_en   = 1'b1;
              state_d = ST_FULL;
            end
          end else begin
            wr_en = 1'b1;
            cnt_d = pix_cnt + ONE;
          end
        end
      end
      ST_FULL: begin
        if (slot_free) begin
          load_asm = 1'b1;
          cnt_d    = '0;
          state_d  = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Assembly buffer: one register per pixel slot.
  generate
    for (genvar i = 0; i < NPIX; i++) begin : g_slot
      // Write this slot when the accepted pixel is addressed to it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          asm_q[i] <= '0;
        end else if (wr_en && (wr_idx == CNT_W'(i))) begin
          asm_q[i] <= pix_in;
        end
      end
    end
  endgenerate

  // Output holding register; frame_out keeps its value after consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_out   <= '0;
      frame_valid <= 1'b0;
    end else if (load_direct) begin
      frame_out   <= {pix_in, asm_flat[FW-PIX_W-1:0]};
      frame_valid <= 1'b1;
    end else if (load_asm) begin
      frame_out   <= asm_flat;
      frame_valid <= 1'b1;
    end else if (consume) begin
      frame_valid <= 1'b0;
    end
  end

  // Pixel index counter and partial-frame abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      err_sof <= 1'b0;
    end else begin
      pix_cnt <= cnt_d;
      err_sof <= sof_abort;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_frame_packer
// Purpose  : Directed and randomised self-checking bench for conv_frame_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_frame_packer;

  localparam int PIX_W = 4;
  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int NPIX  = ROWS * COLS;
  localparam int FW    = NPIX * PIX_W;

  logic              clk;
  logic              rst_n;
  logic [PIX_W-1:0]  pix_in;
  logic              pix_valid;
  logic              pix_sof;
  logic              pix_ready;
  logic [FW-1:0]     frame_out;
  logic              frame_valid;
  logic              frame_ready;
  logic [4:0]        pix_cnt;
  logic              err_sof;

  int checks = 0;
  int errors = 0;

  conv_frame_packer #(
    .PIX_W (PIX_W),
    .ROWS  (ROWS),
    .COLS  (COLS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .pix_cnt     (pix_cnt),
    .err_sof     (err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel for exactly one edge.
  task automatic send_pix(input logic [PIX_W-1:0] v, input logic sof);
    pix_in    = v;
    pix_sof   = sof;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  logic [FW-1:0]     exp_frame;
  logic [FW-1:0]     mframe;
  logic [FW-1:0]     prev_out;
  logic [FW-1:0]     q[$];
  logic [PIX_W-1:0]  v;
  logic              prev_hold;
  int                mcnt;
  int                ready_err;
  int                valid_err;
  int                stab_err;
  int                n_built;
  int                n_cons;

  initial begin
    rst_n       = 1'b0;
    pix_in      = '0;
    pix_valid   = 1'b0;
    pix_sof     = 1'b0;
    frame_ready = 1'b0;
    tick();
    tick();
    check("rst_ready", pix_ready, 1);
    check("rst_valid", frame_valid, 0);
    check("rst_frame", frame_out, 0);
    check("rst_cnt", pix_cnt, 0);
    check("rst_err", err_sof, 0);
    #3 rst_n = 1'b1;
    tick();

    // ---- single frame, k mod 16 ----
    frame_ready = 1'b1;
    exp_frame   = '0;
    for (int k = 0; k < NPIX; k++) begin
      v = PIX_W'(k % 16);
      exp_frame[PIX_W*k +: PIX_W] = v;
      send_pix(v, 1'b0);
    end
    check("f1_valid", frame_valid, 1);
    check("f1_frame", frame_out, exp_frame);
    check("f1_nib0", frame_out[3:0], 4'h0);
    check("f1_nib1", frame_out[7:4], 4'h1);
    check("f1_nib15", frame_out[63:60], 4'hF);
    check("f1_nib16", frame_out[67:64], 4'h0);
    check("f1_nib24", frame_out[99:96], 4'h8);
    check("f1_cnt", pix_cnt, 0);
    tick();
    check("f1_pulse", frame_valid, 0);

    // ---- three back-to-back frames ----
    ready_err = 0;
    valid_err = 0;
    for (int f = 0; f < 3; f++) begin
      exp_frame = '0;
      for (int k = 0; k < NPIX; k++) begin
        v = PIX_W'((k + 7 * f + 3) % 16);
        exp_frame[PIX_W*k +: PIX_W] = v;
        if (pix_ready !== 1'b1) ready_err++;
        send_pix(v, 1'b0);
        if (frame_valid !== (k == NPIX - 1)) valid_err++;
      end
      check("b2b_frame", frame_out, exp_frame);
    end
    check("b2b_ready", ready_err, 0);
    check("b2b_valid", valid_err, 0);
    tick();

    // ---- backpressure: A held, B fills and blocks ----
    frame_ready = 1'b0;
    for (int k = 0; k < NPIX; k++) send_pix(4'h3, 1'b0);
    check("bp_a_valid", frame_valid, 1);
    check("bp_a_frame", frame_out, {NPIX{4'h3}});
    for (int k = 0; k < NPIX; k++) send_pix(4'hC, 1'b0);
    check("bp_full_ready", pix_ready, 0);
    check("bp_full_cnt", pix_cnt, 24);
    tick();
    tick();
    check("bp_hold_frame", frame_out, {NPIX{4'h3}});
    check("bp_hold_valid", frame_valid, 1);
    check("bp_hold_ready", pix_ready, 0);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("bp_b_frame", frame_out, {NPIX{4'hC}});
    check("bp_b_valid", frame_valid, 1);
    check("bp_b_ready", pix_ready, 1);
    check("bp_b_cnt", pix_cnt, 0);
    frame_ready = 1'b1;
    tick();
    check("bp_drain", frame_valid, 0);

    // ---- sof abort at pix_cnt = 10 ----
    for (int k = 0; k < 10; k++) send_pix(PIX_W'(k), 1'b0);
    check("sof_pre_cnt", pix_cnt, 10);
    send_pix(4'hA, 1'b1);
    check("sof_err", err_sof, 1);
    check("sof_cnt", pix_cnt, 1);
    exp_frame = '0;
    exp_frame[3:0] = 4'hA;
    for (int k = 1; k < NPIX; k++) begin
      v = PIX_W'((k + 5) % 16);
      exp_frame[PIX_W*k +: PIX_W] = v;
      send_pix(v, 1'b0);
      if (k == 1) check("sof_err_one", err_sof, 0);
      if (k < NPIX - 1) begin
        if (frame_valid !== 1'b0) check("sof_early_valid", frame_valid, 0);
      end
    end
    check("sof_valid", frame_valid, 1);
    check("sof_frame", frame_out, exp_frame);
    tick();

    // ---- asynchronous reset mid-frame with a held frame ----
    frame_ready = 1'b0;
    for (int k = 0; k < NPIX; k++) send_pix(4'h5, 1'b0);
    for (int k = 0; k < 12; k++) send_pix(4'h9, 1'b0);
    check("ar_pre_cnt", pix_cnt, 12);
    check("ar_pre_valid", frame_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", frame_valid, 0);
    check("ar_frame", frame_out, 0);
    check("ar_cnt", pix_cnt, 0);
    check("ar_err", err_sof, 0);
    #3 rst_n = 1'b1;
    tick();
    frame_ready = 1'b1;
    exp_frame = '0;
    for (int k = 0; k < NPIX; k++) begin
      v = PIX_W'((k * 7) % 16);
      exp_frame[PIX_W*k +: PIX_W] = v;
      send_pix(v, 1'b0);
    end
    check("ar_post_valid", frame_valid, 1);
    check("ar_post_frame", frame_out, exp_frame);
    tick();

    // ---- random bubbles and backpressure against a reference packer ----
    mframe    = '0;
    mcnt      = 0;
    stab_err  = 0;
    n_built   = 0;
    n_cons    = 0;
    prev_hold = 1'b0;
    prev_out  = '0;
    for (int c = 0; c < 1500; c++) begin
      if (prev_hold && ((frame_out !== prev_out) || (frame_valid !== 1'b1))) stab_err++;
      if (c < 1490) begin
        pix_valid   = 1'($urandom_range(0, 1));
        pix_in      = PIX_W'($urandom);
        frame_ready = 1'($urandom_range(0, 1));
      end else begin
        pix_valid   = 1'b0;
        frame_ready = 1'b1;
      end
      if (frame_valid && frame_ready) begin
        n_cons++;
        if (q.size() == 0) check("rnd_extra", 1, 0);
        else check("rnd_frame", frame_out, q.pop_front());
      end
      if (pix_valid && pix_ready) begin
        mframe[PIX_W*mcnt +: PIX_W] = pix_in;
        mcnt++;
        if (mcnt == NPIX) begin
          q.push_back(mframe);
          mcnt = 0;
          n_built++;
        end
      end
      prev_hold = frame_valid && !frame_ready;
      prev_out  = frame_out;
      tick();
    end
    pix_valid = 1'b0;
    check("rnd_stable", stab_err, 0);
    check("rnd_pending", q.size(), 0);
    check("rnd_count", n_cons, n_built);
    if (n_built < 10) check("rnd_enough", n_built, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_frame_packer.md
# conv_frame_packer

Assembles a raster-order stream of 4-bit pixels into the packed 5x5 frame word consumed by the 3x3 convolution stage. Pixel k (k = row*5 + col) occupies frame bits [4k+3:4k], so row 0 col 0 is in [3:0] and row 4 col 4 is in [99:96]. The block sits between the pixel source and the convolution core. It provides an assembly buffer plus an output holding register, so a new frame can fill while the previous one waits to be consumed.

## Interface
- PIX_W, 4, pixel width in bits
- ROWS, 5, frame rows
- COLS, 5, frame columns (frame width FW = ROWS*COLS*PIX_W = 100; NPIX = 25)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pix_in  input  PIX_W  pixel data
- pix_valid  input  1  pixel present
- pix_sof  input  1  start-of-frame marker, qualified by pixel acceptance
- pix_ready  output  1  block can accept a pixel
- frame_out  output  FW  packed frame, stable while frame_valid=1
- frame_valid  output  1  frame_out holds an unconsumed frame
- frame_ready  input  1  downstream consumes frame
- pix_cnt  output  5  index of next pixel to be written (0..24)
- err_sof  output  1  one-cycle pulse: partial frame aborted by pix_sof

## Operation
- Pixel acceptance: pix_valid & pix_ready. Frame consumption: frame_valid & frame_ready.
- Two states:
  - FILL: pix_ready=1.
  - FULL: assembly buffer holds a complete frame that is blocked; pix_ready=0.
- Accepted pixel with pix_cnt<24: written to assembly slot pix_cnt; pix_cnt increments.
- Accepted pixel with pix_cnt=24 (last):
  - If output slot is free (frame_valid=0) or being consumed this cycle, frame_out <= {pix_in, assembly[95:0]}, frame_valid <= 1, pix_cnt <= 0, stay in FILL.
  - Otherwise the pixel is written to slot 24 and the state goes to FULL; pix_cnt holds at 24.
- FULL: when frame_valid=0 or a frame is consumed this cycle, frame_out <= assembly, frame_valid <= 1, pix_cnt <= 0, next state FILL.
- Consumption without a new load: frame_valid <= 0; frame_out keeps its last value.
- pix_sof on an accepted pixel:
  - pix_cnt=0: normal first pixel.
  - pix_cnt!=0: partial frame discarded. The pixel is written as k=0, pix_cnt <= 1, and err_sof pulses high the next cycle.
- pix_sof is optional. Pixel 25 after a completed frame is always k=0.
- pix_sof and the last-pixel rule: an sof pixel is never treated as pixel 24. The sof rule takes priority.
- Stale assembly slots are never emitted, because all 25 are rewritten before any transfer.
- pix_valid=0 cycles (bubbles) have no effect on content.

## Timing
- Reset values (asynchronous, while rst_n=0): state FILL, pix_ready=1, frame_valid=0, frame_out=0, pix_cnt=0, err_sof=0, assembly buffer=0.
- Reset mid-frame discards the partial frame and any held frame. There is no err_sof pulse on reset.
- Latency: frame_valid rises on the clk edge that accepts pixel 24 (registered, visible the following cycle).
- Throughput: with frame_ready held at 1, one pixel per cycle continuously. pix_ready never drops and a frame is produced every 25 cycles.
- pix_ready is driven from state only (registered); it has no combinational path from frame_ready.
- Recovery from FULL: the transfer occurs in the consume cycle, and pix_ready=1 in the next cycle.
- frame_out and frame_valid are held stable while frame_valid=1 and frame_ready=0.

## Test plan
- Reset, then stream k=0..24 with value k mod 16, frame_ready=1 -> one cycle after the 25th acceptance, frame_valid=1 for one cycle. frame_out[3:0]=0, [7:4]=1, [63:60]=F, [67:64]=0, [99:96]=8.
- Three back-to-back frames, frame_ready=1 -> pix_ready is constantly 1 and frame_valid pulses on cycles 25, 50 and 75 after the first pixel. Each frame_out matches its input.
- frame_ready=0; send frame A (all 0x3) then frame B (all 0xC):
  - After B's last pixel, pix_ready=0 and frame_out stays 0x333...3.
  - Pulse frame_ready for 1 cycle -> next cycle frame_out=0xCCC...C, frame_valid=1, and pix_ready=1.
- Assert pix_sof on the pixel accepted at pix_cnt=10 -> err_sof=1 for exactly one cycle and pix_cnt=1. The frame is emitted after 24 further pixels, with that pixel in bits [3:0].
- Deassert rst_n asynchronously at pix_cnt=12 with a held frame -> immediately frame_valid=0, frame_out=0, pix_cnt=0. The next 25 pixels form a correct frame.
- Random pix_valid bubbles (50%) and random frame_ready -> emitted frames equal the reference packing. There are no lost or duplicated frames, and frame_out is never changed while frame_valid=1 and frame_ready=0.
